morse_key_decoder: RTL and testbench
====================================

Name: morse_key_decoder

Overview:
Front-end controller for the Morse seven-segment display block. It samples a single Morse key, times presses and gaps in programmable time units, and classifies each press as dot or dash. At each letter gap it resolves the accumulated symbols to a letter index A=0..Z=25, using the same encoding as the display block. It then drives that block's start/letter inputs and flags invalid codes.

Parameters:
TICK_DIV, 1000, clock cycles per Morse time unit (>=2; benches use 4)
DASH_UNITS, 2, press length in units at or above which a symbol is a dash
LETTER_GAP_UNITS, 3, released time in units that terminates a letter (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
enable_i  input  1  decoder enable; low forces IDLE and discards the partial letter
key_i  input  1  raw Morse key level, 1 = pressed, asynchronous to clk
letter_o  output  5  last decoded letter index 0..25, held until the next valid emit
letter_valid_o  output  1  one-cycle pulse when letter_o updates
start_o  output  1  display start; goes high with the first valid letter and stays high
error_o  output  1  one-cycle pulse on an undecodable or overlong symbol sequence
busy_o  output  1  high in PRESS, GAP or EMIT
sym_count_o  output  3  symbols accumulated in the current letter, 0..4

Behaviour:
- Reset values:
  - clk and rst: one clock; reset is synchronous and active-high.
  - While rst=1, at each clk edge: state=IDLE, all outputs 0, letter_o=0, internal code, count, prescaler, unit counter and overflow flag all cleared.
- key_i passes through a 2-FF synchronizer into key_s, giving 2 cycles of input latency. Edge detection uses key_s and its previous value.
- Prescaler:
  - Counts 0..TICK_DIV-1 and asserts tick on the TICK_DIV-1 cycle, then wraps to 0.
  - It is cleared on every transition into PRESS or GAP.
  - The unit counter increments on tick and is 3 bits, saturating at 7. It is cleared on every transition into PRESS or GAP.
- States IDLE, PRESS, GAP, EMIT:
  - IDLE:
    - Rising edge of key_s -> PRESS.
    - A release has no effect.
  - PRESS:
    - Count units while key_s=1.
    - On the falling edge of key_s, the symbol is dash (1) if units >= DASH_UNITS, else dot (0). A 0-unit press is a dot.
    - code <= {code[2:0], sym}.
    - If count==4, set overflow, keep count at 4 and leave code unchanged. Otherwise count <= count+1.
    - -> GAP.
  - GAP:
    - Count units while key_s=0.
    - A rising edge of key_s before units reach LETTER_GAP_UNITS -> PRESS (same letter).
    - If the tick that makes units == LETTER_GAP_UNITS and a rising edge occur in the same cycle, the gap wins: -> EMIT. The press is ignored until the key is released and pressed again.
    - Otherwise, units reaching LETTER_GAP_UNITS -> EMIT.
  - EMIT (exactly one cycle):
    - Look up (count, code[count-1:0]) using standard International Morse A..Z, first symbol in the MSB. Examples: A=(2,01), E=(1,0), T=(1,1), S=(3,000), O=(3,111), B=(4,1000), Z=(4,1100).
    - On a match with no overflow: letter_o <= index, letter_valid_o=1 and start_o <= 1, all on the next cycle.
    - Otherwise: error_o=1 on the next cycle, and letter_o and start_o are unchanged.
    - Clear code, count and overflow. -> IDLE.
- Latency:
  - letter_valid_o and error_o are registered.
  - Each asserts exactly 2 cycles after the tick that completes the letter gap: tick at cycle N, EMIT at N+1, pulse at N+2.
- enable_i=0, any state:
  - Next state is IDLE; code, count and overflow are cleared; start_o is cleared.
  - No pulse is emitted and letter_o is held.
  - On re-enable while the key is held, no PRESS starts until a new rising edge.
- A key held indefinitely stays in PRESS with units saturated at 7, which is a dash.
- sym_count_o mirrors count combinationally from the register. busy_o = (state != IDLE).

Test Plan:
- Reset: assert rst for 3 cycles with key_i=1 -> all outputs 0 and IDLE. After rst drops and the key is still held, no PRESS starts until key_i goes 0 then 1.
- Letter A (TICK_DIV=4): press 4 cycles, release 4, press 12, release 16 -> letter_valid_o single pulse, letter_o=0, start_o=1; sym_count_o returns to 0.
- E then T: 4-cycle press followed by a 16-cycle gap, then a 12-cycle press followed by a 16-cycle gap -> two pulses, letter_o=4 then 19, start_o stays 1.
- Invalid ..-- and overlong .....: each ends with a 16-cycle gap -> error_o pulse, no letter_valid_o, letter_o keeps its previous value; the overlong case shows sym_count_o saturating at 4.
- Gap boundary: an intra-letter gap of 11 cycles keeps the same letter (S = three dots -> letter_o=18). A gap of exactly 12 cycles splits it into E E; a press landing on the completing tick is ignored.
- enable_i dropped in GAP after "-.." (D, partial) -> no pulse, start_o=0, sym_count_o=0. After re-enable, "---" followed by a gap -> letter_o=14.

Source files
------------

// File: rtl/morse_key_decoder_if.sv
// Handshake bundle between the Morse key front end and its host/display side.
// The master side drives the key and enable; the decoder (slave) reports letters and status.
interface morse_key_decoder_if;
    logic       enable_i;
    logic       key_i;
    logic [4:0] letter_o;
    logic       letter_valid_o;
    logic       start_o;
    logic       error_o;
    logic       busy_o;
    logic [2:0] sym_count_o;

    modport master (
        output enable_i,
        output key_i,
        input  letter_o,
        input  letter_valid_o,
        input  start_o,
        input  error_o,
        input  busy_o,
        input  sym_count_o
    );

    modport slave (
        input  enable_i,
        input  key_i,
        output letter_o,
        output letter_valid_o,
        output start_o,
        output error_o,
        output busy_o,
        output sym_count_o
    );
endinterface

// File: rtl/morse_key_decoder.sv
// Morse key front end: times presses/gaps in Morse units, classifies dot/dash,
// and resolves each letter to an index A=0..Z=25 for the seven-segment display block.
module morse_key_decoder #(
    parameter int unsigned TICK_DIV         = 1000,
    parameter int unsigned DASH_UNITS       = 2,
    parameter int unsigned LETTER_GAP_UNITS = 3
) (
    input  logic               clk,
    input  logic               rst,
    morse_key_decoder_if.slave bus
);

    localparam int unsigned    PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

    state_t        state;
    logic          key_p0;
    logic          key_s;
    logic          key_s_p1;
    logic          key_rise;
    logic          key_fall;
    logic [PW-1:0] presc;
    logic          tick;
    logic [2:0]    units;
    logic          sym_dash;
    logic          gap_done;
    logic [3:0]    code;
    logic [2:0]    count;
    logic          ovf;
    logic [5:0]    hit;
    logic [4:0]    letter_q;
    logic          vld_q;
    logic          err_q;
    logic          start_q;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    // Returns {match, index}; code is right-aligned with the first symbol in the MSB, dash = 1.
    function automatic logic [5:0] lookup(input logic [2:0] cnt, input logic [3:0] c);
        logic [5:0] r;
        r = 6'd0;
        case ({cnt, c})
            7'b010_0001: r = {1'b1, 5'd0};
            7'b100_1000: r = {1'b1, 5'd1};
            7'b100_1010: r = {1'b1, 5'd2};
            7'b011_0100: r = {1'b1, 5'd3};
            7'b001_0000: r = {1'b1, 5'd4};
            7'b100_0010: r = {1'b1, 5'd5};
            7'b011_0110: r = {1'b1, 5'd6};
            7'b100_0000: r = {1'b1, 5'd7};
            7'b010_0000: r = {1'b1, 5'd8};
            7'b100_0111: r = {1'b1, 5'd9};
            7'b011_0101: r = {1'b1, 5'd10};
            7'b100_0100: r = {1'b1, 5'd11};
            7'b010_0011: r = {1'b1, 5'd12};
            7'b010_0010: r = {1'b1, 5'd13};
            7'b011_0111: r = {1'b1, 5'd14};
            7'b100_0110: r = {1'b1, 5'd15};
            7'b100_1101: r = {1'b1, 5'd16};
            7'b011_0010: r = {1'b1, 5'd17};
            7'b011_0000: r = {1'b1, 5'd18};
            7'b001_0001: r = {1'b1, 5'd19};
            7'b011_0001: r = {1'b1, 5'd20};
            7'b100_0001: r = {1'b1, 5'd21};
            7'b011_0011: r = {1'b1, 5'd22};
            7'b100_1001: r = {1'b1, 5'd23};
            7'b100_1011: r = {1'b1, 5'd24};
            7'b100_1100: r = {1'b1, 5'd25};
            default:     r = 6'd0;
        endcase
        return r;
    endfunction

    // Synchronizer stays out of reset so a key held through reset is not seen as a new press.
    always_ff @(posedge clk) begin
        key_p0   <= bus.key_i;
        key_s    <= key_p0;
        key_s_p1 <= key_s;
    end

    assign key_rise = key_s & ~key_s_p1;
    assign key_fall = ~key_s & key_s_p1;
    assign tick     = (presc == TICK_LAST);
    assign sym_dash = (32'(units) >= DASH_UNITS);
    assign gap_done = tick && ((32'(units) + 32'd1) == LETTER_GAP_UNITS);
    assign hit      = lookup(count, code);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            units    <= 3'd0;
            code     <= 4'd0;
            count    <= 3'd0;
            ovf      <= 1'b0;
            letter_q <= 5'd0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            if (!bus.enable_i) begin
                state   <= IDLE;
                presc   <= '0;
                units   <= 3'd0;
                code    <= 4'd0;
                count   <= 3'd0;
                ovf     <= 1'b0;
                start_q <= 1'b0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    units <= sat_inc(units);
                end
                case (state)
                    IDLE: begin
                        if (key_rise) begin
                            state <= PRESS;
                            presc <= '0;
                            units <= 3'd0;
                        end
                    end
                    PRESS: begin
                        if (key_fall) begin
                            if (count == 3'd4) begin
                                ovf <= 1'b1;
                            end else begin
                                code  <= {code[2:0], sym_dash};
                                count <= count + 3'd1;
                            end
                            state <= GAP;
                            presc <= '0;
                            units <= 3'd0;
                        end
                    end
                    GAP: begin
                        // A press landing on the gap-completing tick loses to the gap.
                        if (gap_done) begin
                            state <= EMIT;
                        end else if (key_rise) begin
                            state <= PRESS;
                            presc <= '0;
                            units <= 3'd0;
                        end
                    end
                    EMIT: begin
                        if (hit[5] && !ovf) begin
                            letter_q <= hit[4:0];
                            vld_q    <= 1'b1;
                            start_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        code  <= 4'd0;
                        count <= 3'd0;
                        ovf   <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.letter_o       = letter_q;
    assign bus.letter_valid_o = vld_q;
    assign bus.start_o        = start_q;
    assign bus.error_o        = err_q;
    assign bus.busy_o         = (state != IDLE);
    assign bus.sym_count_o    = count;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: directed letters plus random keying, checked every
// cycle against a cycle-counting Morse model with a string code table.
module tb_morse_key_decoder;
    localparam int TD   = 4;
    localparam int DASH = 2;
    localparam int LG   = 3;
    localparam int MI = 0, MP = 1, MG = 2, ME = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    morse_key_decoder_if bus();

    morse_key_decoder #(
        .TICK_DIV(TD),
        .DASH_UNITS(DASH),
        .LETTER_GAP_UNITS(LG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    string morse_tab [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                              ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                              "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int got[$];

    // model state
    bit    m_s0 = 0, m_s1 = 0, m_s2 = 0;
    int    m_mode = MI;
    int    m_cnt  = 0;
    string m_seq  = "";
    bit    m_ovf  = 0;
    int    e_letter = 0;
    int    e_valid  = 0;
    int    e_err    = 0;
    int    e_start  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int find_letter(input string s);
        int r;
        r = -1;
        for (int i = 0; i < 26; i++) if (morse_tab[i] == s) r = i;
        return r;
    endfunction

    // Reference: counts raw cycles in each phase; a press of P cycles spans (P-1)/TD whole units.
    initial begin : model_p
        bit ks, kd, rise, fall;
        int u, idx;
        forever begin
            @(posedge clk);
            ks = m_s1; kd = m_s2;
            rise = ks & ~kd;
            fall = ~ks & kd;
            if (rst) begin
                m_mode = MI; m_seq = ""; m_ovf = 0; m_cnt = 0;
                e_letter = 0; e_valid = 0; e_err = 0; e_start = 0;
            end else begin
                e_valid = 0; e_err = 0;
                if (bus.enable_i !== 1'b1) begin
                    m_mode = MI; m_seq = ""; m_ovf = 0; e_start = 0;
                end else begin
                    case (m_mode)
                        MI: if (rise) begin m_mode = MP; m_cnt = 1; end
                        MP: begin
                            if (fall) begin
                                u = (m_cnt - 1) / TD;
                                if (u > 7) u = 7;
                                if (m_seq.len() == 4) m_ovf = 1;
                                else m_seq = {m_seq, (u >= DASH) ? "-" : "."};
                                m_mode = MG; m_cnt = 1;
                            end else m_cnt++;
                        end
                        MG: begin
                            if (m_cnt == LG * TD) m_mode = ME;
                            else if (rise) begin m_mode = MP; m_cnt = 1; end
                            else m_cnt++;
                        end
                        default: begin
                            idx = find_letter(m_seq);
                            if (!m_ovf && idx >= 0) begin
                                e_letter = idx; e_valid = 1; e_start = 1;
                            end else e_err = 1;
                            m_seq = ""; m_ovf = 0; m_mode = MI;
                        end
                    endcase
                end
            end
            m_s2 = m_s1; m_s1 = m_s0; m_s0 = bus.key_i;
        end
    end

    initial begin : compare_p
        forever begin
            @(negedge clk);
            chk("letter_o", 32'(bus.letter_o), e_letter);
            chk("letter_valid_o", 32'(bus.letter_valid_o), e_valid);
            chk("error_o", 32'(bus.error_o), e_err);
            chk("start_o", 32'(bus.start_o), e_start);
            chk("busy_o", 32'(bus.busy_o), (m_mode != MI) ? 1 : 0);
            chk("sym_count_o", 32'(bus.sym_count_o), m_seq.len());
            if (bus.letter_valid_o === 1'b1) begin
                n_valid++;
                got.push_back(int'(bus.letter_o));
            end
            if (bus.error_o === 1'b1) n_err++;
        end
    end

    task automatic seg(input bit k, input int n);
        bus.key_i = k;
        repeat (n) @(negedge clk);
    endtask

    task automatic dot();  seg(1, 4);  endtask
    task automatic dash(); seg(1, 12); endtask

    initial begin : stim_p
        int v0, e0, ns, pl;
        bus.enable_i = 1'b1;
        bus.key_i    = 1'b1;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.busy", 32'(bus.busy_o), 0);
        chk("rst.letter", 32'(bus.letter_o), 0);
        chk("rst.start", 32'(bus.start_o), 0);
        chk("rst.symcnt", 32'(bus.sym_count_o), 0);
        rst = 1'b0;
        seg(1, 6);
        chk("rst.held_no_press", 32'(bus.busy_o), 0);
        seg(0, 4);

        // A
        v0 = n_valid;
        dot(); seg(0, 4); dash(); seg(0, 16); seg(0, 6);
        chk("A.pulses", n_valid - v0, 1);
        chk("A.letter", 32'(bus.letter_o), 0);
        chk("A.start", 32'(bus.start_o), 1);
        chk("A.symcnt", 32'(bus.sym_count_o), 0);

        // E then T
        v0 = n_valid;
        dot(); seg(0, 16); dash(); seg(0, 16); seg(0, 6);
        chk("ET.pulses", n_valid - v0, 2);
        chk("ET.first", got[got.size()-2], 4);
        chk("ET.second", got[got.size()-1], 19);

        // ..-- is not a letter
        v0 = n_valid; e0 = n_err;
        dot(); seg(0, 4); dot(); seg(0, 4); dash(); seg(0, 4); dash(); seg(0, 16); seg(0, 6);
        chk("inv.errors", n_err - e0, 1);
        chk("inv.pulses", n_valid - v0, 0);
        chk("inv.letter_held", 32'(bus.letter_o), 19);

        // five dots overflow
        v0 = n_valid; e0 = n_err;
        for (int i = 0; i < 5; i++) begin dot(); seg(0, 4); end
        chk("ovf.symcnt_sat", 32'(bus.sym_count_o), 4);
        seg(0, 12); seg(0, 6);
        chk("ovf.errors", n_err - e0, 1);
        chk("ovf.pulses", n_valid - v0, 0);
        chk("ovf.letter_held", 32'(bus.letter_o), 19);

        // S with 11-cycle gaps
        dot(); seg(0, 11); dot(); seg(0, 11); dot(); seg(0, 16); seg(0, 6);
        chk("S.letter", 32'(bus.letter_o), 18);

        // 12-cycle gap: letter ends, the press on the completing tick is dropped
        v0 = n_valid;
        dot(); seg(0, 12); dot(); seg(0, 4); dot(); seg(0, 16); seg(0, 6);
        chk("EE.pulses", n_valid - v0, 2);
        chk("EE.first", got[got.size()-2], 4);
        chk("EE.second", got[got.size()-1], 4);

        // long hold saturates to a dash
        seg(1, 60); seg(0, 16); seg(0, 6);
        chk("hold.letter", 32'(bus.letter_o), 19);

        // disable during partial D, then O
        v0 = n_valid;
        dash(); seg(0, 4); dot(); seg(0, 4); dot(); seg(0, 4);
        bus.enable_i = 1'b0;
        seg(0, 3);
        chk("dis.busy", 32'(bus.busy_o), 0);
        chk("dis.start", 32'(bus.start_o), 0);
        chk("dis.symcnt", 32'(bus.sym_count_o), 0);
        chk("dis.pulses", n_valid - v0, 0);
        bus.enable_i = 1'b1;
        dash(); seg(0, 4); dash(); seg(0, 4); dash(); seg(0, 16); seg(0, 6);
        chk("O.letter", 32'(bus.letter_o), 14);
        chk("O.start", 32'(bus.start_o), 1);

        // press begun while disabled is not a press after re-enable
        v0 = n_valid; e0 = n_err;
        bus.enable_i = 1'b0;
        seg(0, 2); seg(1, 4);
        bus.enable_i = 1'b1;
        seg(1, 8); seg(0, 20);
        chk("reen.pulses", n_valid - v0, 0);
        chk("reen.errors", n_err - e0, 0);
        chk("reen.busy", 32'(bus.busy_o), 0);

        // random keying
        for (int l = 0; l < 60; l++) begin
            ns = $urandom_range(1, 4);
            if ($urandom_range(0, 9) == 0) ns = $urandom_range(5, 6);
            for (int s = 0; s < ns; s++) begin
                case ($urandom_range(0, 3))
                    0:       pl = $urandom_range(1, 4);
                    1:       pl = $urandom_range(5, 9);
                    default: pl = $urandom_range(10, 30);
                endcase
                seg(1, pl);
                if ($urandom_range(0, 15) == 0) begin
                    bus.enable_i = 1'b0;
                    seg($urandom_range(0, 1) == 1, $urandom_range(1, 6));
                    bus.enable_i = 1'b1;
                end
                if (s < ns - 1) seg(0, $urandom_range(1, 13));
            end
            seg(0, $urandom_range(10, 24));
        end
        seg(0, 30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
